uniq_lru: RTL and testbench

UNIQ_LRU -- requirements
Module: uniq_lru

---
 rtl/uniq_lru.sv | 116 +++++++++++
 tb/tb_uniq_lru.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uniq_lru.sv
// Tracks up to DEPTH distinct recent data values, newest in entry 0.
// Reports a hit or an eviction one cycle after each accepted sample.
module uniq_lru #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int MODE  = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       data_en,
   input  logic                       flush,
   output logic [DEPTH*WIDTH-1:0]     out_data,
   output logic [DEPTH-1:0]           out_val,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       hit,
   output logic [$clog2(DEPTH)-1:0]   hit_idx,
   output logic                       evict,
   output logic [WIDTH-1:0]           evict_data
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   logic [WIDTH-1:0] ent   [DEPTH];
   logic [WIDTH-1:0] ent_n [DEPTH];
   logic [DEPTH-1:0] match;
   logic             hit_any;
   logic [IW-1:0]    hit_i;
   logic [DEPTH-1:0] val_n;
   logic [CW-1:0]    cnt_n;
   logic             hit_n;
   logic [IW-1:0]    idx_n;
   logic             ev_n;
   logic [WIDTH-1:0] evd_n;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         out_data[k*WIDTH +: WIDTH] = ent[k];
      end
   end

   // Invalid entries are gated out so a stored 0 never aliases an empty slot.
   always_comb begin
      match   = '0;
      hit_any = 1'b0;
      hit_i   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match[k] = out_val[k] && (ent[k] == data_in);
         if (match[k]) begin
            hit_any = 1'b1;
            hit_i   = IW'(k);
         end
      end
   end

   always_comb begin
      ent_n = ent;
      val_n = out_val;
      cnt_n = count;
      hit_n = 1'b0;
      idx_n = '0;
      ev_n  = 1'b0;
      evd_n = '0;
      if (flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent_n[k] = '0;
         end
         val_n = '0;
         cnt_n = '0;
      end else if (data_en) begin
         if (hit_any) begin
            hit_n = 1'b1;
            idx_n = hit_i;
            if (MODE == 0) begin
               for (int k = 1; k < DEPTH; k++) begin
                  if (k <= int'(hit_i)) ent_n[k] = ent[k-1];
               end
               ent_n[0] = data_in;
            end
         end else begin
            ev_n  = out_val[DEPTH-1];
            evd_n = out_val[DEPTH-1] ? ent[DEPTH-1] : '0;
            for (int k = 1; k < DEPTH; k++) begin
               ent_n[k] = ent[k-1];
            end
            ent_n[0] = data_in;
            val_n    = {out_val[DEPTH-2:0], 1'b1};
            if (count != CW'(DEPTH)) cnt_n = count + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ent[k] <= '0;
         end
         out_val    <= '0;
         count      <= '0;
         hit        <= 1'b0;
         hit_idx    <= '0;
         evict      <= 1'b0;
         evict_data <= '0;
      end else begin
         ent        <= ent_n;
         out_val    <= val_n;
         count      <= cnt_n;
         hit        <= hit_n;
         hit_idx    <= idx_n;
         evict      <= ev_n;
         evict_data <= evd_n;
      end
   end

endmodule

// File: tb/tb_uniq_lru.sv
// Bench for uniq_lru: runs MODE=0 and MODE=1 instances side by side
// against a behavioural model feeding per-instance scoreboards.
module tb_uniq_lru;

   typedef struct packed {
      logic [31:0] od;
      logic [3:0]  ov;
      logic [2:0]  cnt;
      logic        hit;
      logic [1:0]  hidx;
      logic        ev;
      logic [7:0]  ed;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  data_in = '0;
   logic        data_en = 1'b0;
   logic        flush = 1'b0;

   logic [31:0] od0, od1;
   logic [3:0]  ov0, ov1;
   logic [2:0]  cnt0, cnt1;
   logic        hit0, hit1, ev0, ev1;
   logic [1:0]  hidx0, hidx1;
   logic [7:0]  ed0, ed1;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t        sb0[$];
   exp_t        sb1[$];
   logic [7:0]  ment [2][4];
   int          mcnt [2];

   uniq_lru #(.WIDTH(8), .DEPTH(4), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_en(data_en), .flush(flush),
      .out_data(od0), .out_val(ov0), .count(cnt0), .hit(hit0), .hit_idx(hidx0),
      .evict(ev0), .evict_data(ed0));

   uniq_lru #(.WIDTH(8), .DEPTH(4), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_en(data_en), .flush(flush),
      .out_data(od1), .out_val(ov1), .count(cnt1), .hit(hit1), .hit_idx(hidx1),
      .evict(ev1), .evict_data(ed1));

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0;
         for (int i = 0; i < 4; i++) ment[m][i] = '0;
      end
   endtask

   // Advance the model for one mode and return the expected registered outputs.
   task automatic model_step(input int m, input logic en, input logic fl,
                             input logic [7:0] d, output exp_t e);
      int idx;
      e = '0;
      if (fl) begin
         mcnt[m] = 0;
         for (int i = 0; i < 4; i++) ment[m][i] = '0;
      end else if (en) begin
         idx = -1;
         for (int i = 0; i < mcnt[m]; i++) if (ment[m][i] == d) idx = i;
         if (idx >= 0) begin
            e.hit  = 1'b1;
            e.hidx = 2'(idx);
            if (m == 0) begin
               for (int i = idx; i > 0; i--) ment[m][i] = ment[m][i-1];
               ment[m][0] = d;
            end
         end else begin
            if (mcnt[m] == 4) begin
               e.ev = 1'b1;
               e.ed = ment[m][3];
            end
            for (int i = 3; i > 0; i--) ment[m][i] = ment[m][i-1];
            ment[m][0] = d;
            if (mcnt[m] < 4) mcnt[m]++;
         end
      end
      e.od  = {ment[m][3], ment[m][2], ment[m][1], ment[m][0]};
      e.cnt = 3'(mcnt[m]);
      e.ov  = 4'((1 << mcnt[m]) - 1);
   endtask

   task automatic sb_compare(input int m);
      exp_t e;
      logic [31:0] od;
      logic [3:0]  ov;
      logic [2:0]  cnt;
      logic        h, ev;
      logic [1:0]  hi;
      logic [7:0]  ed;
      if (m == 0) begin
         od = od0; ov = ov0; cnt = cnt0; h = hit0; hi = hidx0; ev = ev0; ed = ed0;
      end else begin
         od = od1; ov = ov1; cnt = cnt1; h = hit1; hi = hidx1; ev = ev1; ed = ed1;
      end
      n_checks++;
      if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
         n_fail++;
         $display("FAIL sb_empty mode%0d: no expected entry queued", m);
         return;
      end
      e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
      if (od !== e.od || ov !== e.ov || cnt !== e.cnt || h !== e.hit || ev !== e.ev ||
          (e.hit && hi !== e.hidx) || (e.ev && ed !== e.ed)) begin
         n_fail++;
         $display("FAIL sb_mode%0d: got od=%h ov=%b cnt=%0d hit=%b idx=%0d ev=%b ed=%h, want od=%h ov=%b cnt=%0d hit=%b idx=%0d ev=%b ed=%h",
                  m, od, ov, cnt, h, hi, ev, ed, e.od, e.ov, e.cnt, e.hit, e.hidx, e.ev, e.ed);
      end
   endtask

   task automatic step(input logic en, input logic fl, input logic [7:0] d);
      exp_t e;
      data_en = en;
      flush   = fl;
      data_in = d;
      model_step(0, en, fl, d, e); sb0.push_back(e);
      model_step(1, en, fl, d, e); sb1.push_back(e);
      @(posedge clk);
      #1;
      data_en = 1'b0;
      flush   = 1'b0;
      sb_compare(0);
      sb_compare(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({od0, ov0, cnt0, hit0, hidx0, ev0, ed0} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got od=%h ov=%b cnt=%0d, want all zero", od0, ov0, cnt0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_fill_hit_evict();
      step(1'b1, 1'b0, 8'd5);
      step(1'b1, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd7);
      step(1'b1, 1'b0, 8'd9);
      n_checks++;
      if (od0 !== 32'h05000709 || ov0 !== 4'b1111 || cnt0 !== 3'd4) begin
         n_fail++;
         $display("FAIL fill: got od=%h ov=%b cnt=%0d, want od=05000709 ov=1111 cnt=4", od0, ov0, cnt0);
      end
      step(1'b1, 1'b0, 8'd0);
      n_checks++;
      if (hit0 !== 1'b1 || hidx0 !== 2'd2 || od0 !== 32'h05070900 || ev0 !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_reorder: got hit=%b idx=%0d od=%h ev=%b, want hit=1 idx=2 od=05070900 ev=0",
                  hit0, hidx0, od0, ev0);
      end
      step(1'b1, 1'b0, 8'd3);
      n_checks++;
      if (ev0 !== 1'b1 || ed0 !== 8'd5 || od0 !== 32'h07090003 || hit0 !== 1'b0) begin
         n_fail++;
         $display("FAIL evict: got ev=%b ed=%0d od=%h hit=%b, want ev=1 ed=5 od=07090003 hit=0",
                  ev0, ed0, od0, hit0);
      end
      step(1'b0, 1'b0, 8'd3);
      n_checks++;
      if (hit0 !== 1'b0 || ev0 !== 1'b0 || od0 !== 32'h07090003) begin
         n_fail++;
         $display("FAIL idle_hold: got hit=%b ev=%b od=%h, want hit=0 ev=0 od=07090003", hit0, ev0, od0);
      end
   endtask

   task automatic test_mode1();
      step(1'b0, 1'b1, 8'd0);
      step(1'b1, 1'b0, 8'd1);
      step(1'b1, 1'b0, 8'd2);
      step(1'b1, 1'b0, 8'd1);
      n_checks++;
      if (hit1 !== 1'b1 || hidx1 !== 2'd1 || od1[15:0] !== 16'h0102 || ov1 !== 4'b0011) begin
         n_fail++;
         $display("FAIL mode1_hit: got hit=%b idx=%0d od=%h ov=%b, want hit=1 idx=1 od[15:0]=0102 ov=0011",
                  hit1, hidx1, od1, ov1);
      end
   endtask

   task automatic test_flush_priority();
      step(1'b1, 1'b0, 8'd6);
      n_checks++;
      if (cnt0 !== 3'd3) begin
         n_fail++;
         $display("FAIL flush_setup: got cnt=%0d, want 3", cnt0);
      end
      step(1'b1, 1'b1, 8'd8);
      n_checks++;
      if (cnt0 !== 3'd0 || ov0 !== 4'b0 || hit0 !== 1'b0 || ev0 !== 1'b0 || od0 !== 32'h0) begin
         n_fail++;
         $display("FAIL flush_priority: got cnt=%0d ov=%b hit=%b ev=%b od=%h, want all zero",
                  cnt0, ov0, hit0, ev0, od0);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({od0, ov0, cnt0, hit0, hidx0, ev0, ed0} !== '0 || {od1, ov1, cnt1} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got od=%h ov=%b cnt=%0d, want all zero before edge", od0, ov0, cnt0);
      end
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'd42);
      n_checks++;
      if (cnt0 !== 3'd1 || od0[7:0] !== 8'd42 || ov0 !== 4'b0001) begin
         n_fail++;
         $display("FAIL post_reset_sample: got cnt=%0d e0=%0d ov=%b, want cnt=1 e0=42 ov=0001",
                  cnt0, od0[7:0], ov0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
              8'($urandom_range(0, 6)));
      end
   endtask

   task automatic test_back_to_back();
      step(1'b0, 1'b1, 8'd0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(i % 6));
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hFF - (i % 2)));
   endtask

   initial begin
      test_reset();
      test_fill_hit_evict();
      test_mode1();
      test_flush_priority();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
